// File: rtl/qam16_slicer_pack.sv
// QAM-16 hard-decision slicer: Gray-codes each corrected I/Q sample, packs symbol
// pairs into bytes and queues them in a small first-word fall-through byte FIFO.
module qam16_slicer_pack #(
    parameter int width = 16,
    parameter int THR   = 4096,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       in_valid,
    input  logic signed [width-1:0]    x_in,
    input  logic signed [width-1:0]    y_in,
    output logic [3:0]                 sym,
    output logic                       sym_valid,
    output logic [7:0]                 byte_data,
    output logic                       byte_valid,
    input  logic                       byte_ready,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       overflow,
    input  logic                       clr_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    typedef enum logic {
        PH_HIGH,
        PH_LOW
    } phase_t;

    phase_t          state_q, state_d;
    logic [3:0]      hold_q, hold_d;
    logic [3:0]      sym_q, sym_d;
    logic            sym_valid_q, sym_valid_d;
    logic [AW-1:0]   wr_q, wr_d;
    logic [AW-1:0]   rd_q, rd_d;
    logic [AW:0]     count_q, count_d;
    logic            ovf_q, ovf_d;
    logic [7:0]      mem_q [DEPTH];

    logic            accept;
    logic            push;
    logic            pop;
    logic            full;
    logic            push_ok;
    logic            drop;
    logic [7:0]      push_byte;

    // Sign-extend by one bit so that -THR is representable for any legal THR.
    function automatic logic [1:0] slice_axis(input logic signed [width-1:0] v);
        logic signed [width:0] v_ext;
        logic signed [width:0] t_pos;
        logic signed [width:0] t_neg;
        v_ext = {v[width-1], v};
        t_pos = (width + 1)'(THR);
        t_neg = -t_pos;
        if (v_ext >= t_pos)
            return 2'b10;
        else if (v_ext >= 0)
            return 2'b11;
        else if (v_ext >= t_neg)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_comb begin
        accept      = start && in_valid;
        sym_d       = accept ? {slice_axis(x_in), slice_axis(y_in)} : sym_q;
        sym_valid_d = accept;

        state_d   = state_q;
        hold_d    = hold_q;
        push      = 1'b0;
        push_byte = {hold_q, sym_q};
        if (!start) begin
            state_d = PH_HIGH;
            hold_d  = '0;
        end else if (sym_valid_q) begin
            case (state_q)
                PH_HIGH: begin
                    hold_d  = sym_q;
                    state_d = PH_LOW;
                end
                PH_LOW: begin
                    push    = 1'b1;
                    state_d = PH_HIGH;
                end
                default: state_d = PH_HIGH;
            endcase
        end
    end

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
        pop     = (count_q != '0) && byte_ready;
        full    = (count_q == FULL_COUNT);
        push_ok = push && (!full || pop);
        drop    = push && full && !pop;

        wr_d = push_ok ? wr_q + 1'b1 : wr_q;
        rd_d = pop ? rd_q + 1'b1 : rd_q;

        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (drop)
            ovf_d = 1'b1;
        else if (clr_ovf)
            ovf_d = 1'b0;
        else
            ovf_d = ovf_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= PH_HIGH;
            hold_q      <= '0;
            sym_q       <= '0;
            sym_valid_q <= 1'b0;
            wr_q        <= '0;
            rd_q        <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            sym_q       <= sym_d;
            sym_valid_q <= sym_valid_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem_q[wr_q] <= push_byte;
    end

    assign sym        = sym_q;
    assign sym_valid  = sym_valid_q;
    assign byte_valid = (count_q != '0);
    assign byte_data  = (count_q != '0) ? mem_q[rd_q] : 8'h00;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_qam16_slicer_pack.sv
// Self-checking bench for qam16_slicer_pack: directed vector table, hand-written
// FIFO/reset corner sequences, then randomized traffic against a queue-based model.
module tb_qam16_slicer_pack;

    localparam int W     = 16;
    localparam int THR   = 4096;
    localparam int DEPTH = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 in_valid;
    logic signed [W-1:0]  x_in;
    logic signed [W-1:0]  y_in;
    logic [3:0]           sym;
    logic                 sym_valid;
    logic [7:0]           byte_data;
    logic                 byte_valid;
    logic                 byte_ready;
    logic [2:0]           fifo_count;
    logic                 overflow;
    logic                 clr_ovf;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        int         x;
        int         y;
        logic [3:0] expSym;
    } sliceVec_t;

    sliceVec_t vecs[8];

    // Reference model state for the randomized phase
    logic [3:0] mSym;
    logic       mSymValid;
    logic       mHaveHigh;
    logic [3:0] mHigh;
    logic [7:0] mQ[$];
    logic       mOvf;
    int         rx;
    int         ry;

    qam16_slicer_pack #(.width(W), .THR(THR), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .x_in      (x_in),
        .y_in      (y_in),
        .sym       (sym),
        .sym_valid (sym_valid),
        .byte_data (byte_data),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .fifo_count(fifo_count),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int x, input int y);
        in_valid = 1'b1;
        x_in     = W'(x);
        y_in     = W'(y);
        tick();
        in_valid = 1'b0;
    endtask

    function automatic int codeVal(input logic [1:0] c);
        case (c)
            2'b10:   return 5000;
            2'b11:   return 100;
            2'b01:   return -100;
            default: return -5000;
        endcase
    endfunction

    task automatic nibbleStrobe(input logic [3:0] nib);
        applyStimulus(codeVal(nib[3:2]), codeVal(nib[1:0]));
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [1:0] modelSlice(input int v);
        if (v >= THR)       return 2'b10;
        else if (v >= 0)    return 2'b11;
        else if (v >= -THR) return 2'b01;
        else                return 2'b00;
    endfunction

    // One clock edge of the reference model, using the inputs held across the edge
    task automatic modelStep();
        logic       doPush;
        logic [7:0] newByte;
        logic       wasFull;
        logic       doPop;
        doPush  = 1'b0;
        newByte = 8'h00;
        if (!start) begin
            mHaveHigh = 1'b0;
        end else if (mSymValid) begin
            if (mHaveHigh) begin
                doPush    = 1'b1;
                newByte   = {mHigh, mSym};
                mHaveHigh = 1'b0;
            end else begin
                mHigh     = mSym;
                mHaveHigh = 1'b1;
            end
        end
        wasFull = (mQ.size() == DEPTH);
        doPop   = (mQ.size() != 0) && byte_ready;
        if (doPop)
            void'(mQ.pop_front());
        if (doPush && wasFull && !doPop)
            mOvf = 1'b1;
        else begin
            if (doPush)
                mQ.push_back(newByte);
            if (clr_ovf)
                mOvf = 1'b0;
        end
        if (start && in_valid)
            mSym = {modelSlice(rx), modelSlice(ry)};
        mSymValid = start && in_valid;
    endtask

    function automatic int randAxis();
        int sel;
        sel = $urandom_range(0, 3);
        case (sel)
            0:       return int'($signed(16'($urandom)));
            1:       return THR + $urandom_range(0, 4) - 2;
            2:       return -THR + $urandom_range(0, 4) - 2;
            default: return $urandom_range(0, 6) - 3;
        endcase
    endfunction

    initial begin
        logic [7:0] ovfBytes[5];
        logic [7:0] fullBytes[5];
        logic [7:0] b;

        vecs[0] = '{4096,   0,      4'b1011};
        vecs[1] = '{4095,   0,      4'b1111};
        vecs[2] = '{0,      0,      4'b1111};
        vecs[3] = '{-1,     0,      4'b0111};
        vecs[4] = '{-4096,  0,      4'b0111};
        vecs[5] = '{-4097,  0,      4'b0011};
        vecs[6] = '{-32768, 0,      4'b0011};
        vecs[7] = '{32767,  -32768, 4'b1000};
        ovfBytes  = '{8'h1E, 8'h2D, 8'h3C, 8'h4B, 8'h5A};
        fullBytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

        start      = 1'b0;
        in_valid   = 1'b0;
        x_in       = '0;
        y_in       = '0;
        byte_ready = 1'b0;
        clr_ovf    = 1'b0;
        doReset();

        checkOutput("reset sym", 32'(sym), 32'h0);
        checkOutput("reset sym_valid", 32'(sym_valid), 32'h0);
        checkOutput("reset byte_valid", 32'(byte_valid), 32'h0);
        checkOutput("reset byte_data", 32'(byte_data), 32'h0);
        checkOutput("reset fifo_count", 32'(fifo_count), 32'h0);
        checkOutput("reset overflow", 32'(overflow), 32'h0);

        start = 1'b1;
        tick(); tick(); tick();
        checkOutput("idle sym_valid", 32'(sym_valid), 32'h0);
        checkOutput("idle byte_valid", 32'(byte_valid), 32'h0);
        checkOutput("idle fifo_count", 32'(fifo_count), 32'h0);

        // First pair: 0x9 then 0x7 packs to 0x97
        applyStimulus(5000, -100);
        checkOutput("pair sym1", 32'(sym), 32'h9);
        checkOutput("pair sym_valid1", 32'(sym_valid), 32'h1);
        applyStimulus(-4096, 4095);
        checkOutput("pair sym2", 32'(sym), 32'h7);
        checkOutput("pair byte_valid early", 32'(byte_valid), 32'h0);
        tick();
        checkOutput("pair sym_valid pulse", 32'(sym_valid), 32'h0);
        checkOutput("pair byte_valid", 32'(byte_valid), 32'h1);
        checkOutput("pair byte_data", 32'(byte_data), 32'h97);
        checkOutput("pair fifo_count", 32'(fifo_count), 32'h1);
        byte_ready = 1'b1;
        tick();
        checkOutput("pair drained", 32'(fifo_count), 32'h0);
        tick();
        checkOutput("ready while empty", 32'(fifo_count), 32'h0);
        checkOutput("ready while empty valid", 32'(byte_valid), 32'h0);
        byte_ready = 1'b0;

        // Threshold boundary sweep, back-to-back strobes
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].x, vecs[i].y);
            checkOutput($sformatf("slice vec%0d", i), 32'(sym), 32'(vecs[i].expSym));
            checkOutput($sformatf("slice valid%0d", i), 32'(sym_valid), 32'h1);
        end
        tick();
        checkOutput("sweep fifo_count", 32'(fifo_count), 32'h4);
        checkOutput("sweep head", 32'(byte_data), 32'hBF);
        doReset();
        checkOutput("reset clears fifo", 32'(fifo_count), 32'h0);

        // Overflow: five bytes into a four-deep FIFO with no sink
        for (int i = 0; i < 4; i++) begin
            b = ovfBytes[i];
            nibbleStrobe(b[7:4]);
            nibbleStrobe(b[3:0]);
        end
        tick();
        checkOutput("fill count", 32'(fifo_count), 32'h4);
        checkOutput("fill no overflow", 32'(overflow), 32'h0);
        b = ovfBytes[4];
        nibbleStrobe(b[7:4]);
        nibbleStrobe(b[3:0]);
        tick();
        checkOutput("ovf count", 32'(fifo_count), 32'h4);
        checkOutput("ovf flag", 32'(overflow), 32'h1);
        byte_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("ovf drain%0d", i), 32'(byte_data), 32'(ovfBytes[i]));
            tick();
        end
        byte_ready = 1'b0;
        checkOutput("ovf drained", 32'(fifo_count), 32'h0);
        checkOutput("ovf sticky", 32'(overflow), 32'h1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        checkOutput("ovf cleared", 32'(overflow), 32'h0);

        // Push into a full FIFO in the same cycle as a pop
        for (int i = 0; i < 4; i++) begin
            b = fullBytes[i];
            nibbleStrobe(b[7:4]);
            nibbleStrobe(b[3:0]);
        end
        tick();
        checkOutput("full count", 32'(fifo_count), 32'h4);
        b = fullBytes[4];
        nibbleStrobe(b[7:4]);
        nibbleStrobe(b[3:0]);
        byte_ready = 1'b1;
        tick();
        byte_ready = 1'b0;
        checkOutput("simul count", 32'(fifo_count), 32'h4);
        checkOutput("simul overflow", 32'(overflow), 32'h0);
        checkOutput("simul head", 32'(byte_data), 32'h22);
        byte_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            checkOutput($sformatf("simul drain%0d", i), 32'(byte_data), 32'(fullBytes[i]));
            tick();
        end
        byte_ready = 1'b0;
        checkOutput("simul drained", 32'(fifo_count), 32'h0);

        // Reset after a captured high nibble must not leave a stale nibble
        applyStimulus(-5000, -5000);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midreset sym", 32'(sym), 32'h0);
        applyStimulus(20480, 20480);
        applyStimulus(20480, 20480);
        tick();
        checkOutput("midreset count", 32'(fifo_count), 32'h1);
        checkOutput("midreset byte", 32'(byte_data), 32'hAA);
        byte_ready = 1'b1;
        tick();
        byte_ready = 1'b0;

        // Dropping start for a cycle discards the half-packed byte
        applyStimulus(-5000, -5000);
        tick();
        start = 1'b0;
        tick();
        start = 1'b1;
        applyStimulus(20480, 20480);
        applyStimulus(20480, 20480);
        tick();
        checkOutput("startlow count", 32'(fifo_count), 32'h1);
        checkOutput("startlow byte", 32'(byte_data), 32'hAA);

        // Randomized traffic against the reference model
        doReset();
        mSym      = 4'h0;
        mSymValid = 1'b0;
        mHaveHigh = 1'b0;
        mHigh     = 4'h0;
        mQ.delete();
        mOvf      = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            start      = ($urandom_range(0, 19) != 0);
            in_valid   = $urandom_range(0, 1);
            rx         = randAxis();
            ry         = randAxis();
            x_in       = W'(rx);
            y_in       = W'(ry);
            byte_ready = ($urandom_range(0, 9) < 4);
            clr_ovf    = ($urandom_range(0, 19) == 0);
            @(posedge clk);
            modelStep();
            #1;
            checkOutput("rand sym", 32'(sym), 32'(mSym));
            checkOutput("rand sym_valid", 32'(sym_valid), 32'(mSymValid));
            checkOutput("rand fifo_count", 32'(fifo_count), 32'(mQ.size()));
            checkOutput("rand byte_valid", 32'(byte_valid), 32'(mQ.size() != 0));
            checkOutput("rand byte_data", 32'(byte_data), (mQ.size() != 0) ? 32'(mQ[0]) : 32'h0);
            checkOutput("rand overflow", 32'(overflow), 32'(mOvf));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
